divisor_frecuencia: RTL and testbench

DIVISOR_FRECUENCIA -- requirements
Module: divisor_frecuencia

---
 rtl/divisor_frecuencia.sv | 50 +++++
 tb/tb_divisor_frecuencia.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/divisor_frecuencia.sv
// Fixed-ratio clock divider: clk_in / DIV with a registered, glitch-free clk_div.
// Low phase is ceil(DIV/2) cycles, high phase floor(DIV/2) cycles.
module divisor_frecuencia #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 9600
) (
    input  logic clk_in,
    input  logic reset,
    output logic clk_div
);

    localparam int DIV_RAW = CLK_FREQ_HZ / BAUD;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int LO      = DIV - (DIV / 2);
    localparam int CW      = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LO   = CW'(LO);

    logic [CW-1:0] cnt_q = '0;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          clk_div_q = 1'b0;
    logic          clk_div_d;

    assign cnt_inc = cnt_q + 1'b1;

    // Output level is decided from the next count so the flop alone drives clk_div.
    always_comb begin
        cnt_d     = cnt_inc;
        clk_div_d = (cnt_inc >= CNT_LO);
        if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            clk_div_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign clk_div = clk_div_q;

endmodule

// File: tb/tb_divisor_frecuencia.sv
// Directed bench for divisor_frecuencia: even, odd, clamped and default ratios,
// mid-period reset and long reset hold.
module tb_divisor_frecuencia;

    logic clk_in = 1'b0;
    logic rst4   = 1'b0;
    logic rst5   = 1'b0;
    logic rst2   = 1'b0;
    logic rstd   = 1'b0;
    logic cd4;
    logic cd5;
    logic cd2;
    logic cdd;

    int vecs = 0;
    int errs = 0;

    always #5 clk_in = ~clk_in;

    divisor_frecuencia #(.CLK_FREQ_HZ(8), .BAUD(2)) u4 (
        .clk_in (clk_in),
        .reset  (rst4),
        .clk_div(cd4)
    );

    divisor_frecuencia #(.CLK_FREQ_HZ(10), .BAUD(2)) u5 (
        .clk_in (clk_in),
        .reset  (rst5),
        .clk_div(cd5)
    );

    divisor_frecuencia #(.CLK_FREQ_HZ(3), .BAUD(2)) u2 (
        .clk_in (clk_in),
        .reset  (rst2),
        .clk_div(cd2)
    );

    divisor_frecuencia u_dflt (
        .clk_in (clk_in),
        .reset  (rstd),
        .clk_div(cdd)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hand-derived waveforms, edge 1 after release is bit 0 (MSB).
    logic [0:9] e4 = 10'b0110011001;
    logic [0:9] e5 = 10'b0011000110;
    logic [0:9] e2 = 10'b1010101010;

    int hi;
    int bad;
    int n;
    logic ex;

    initial begin
        #1;
        chk("pwrup_d4", cd4, 1'b0);
        chk("pwrup_d5", cd5, 1'b0);
        chk("pwrup_d2", cd2, 1'b0);
        chk("pwrup_dflt", cdd, 1'b0);

        #1;
        rst4 = 1'b1;
        rst5 = 1'b1;
        rst2 = 1'b1;
        rstd = 1'b1;
        tick();
        tick();
        chk("rst_d4", cd4, 1'b0);
        chk("rst_d5", cd5, 1'b0);
        chk("rst_d2", cd2, 1'b0);
        chk("rst_dflt", cdd, 1'b0);
        rst4 = 1'b0;
        rst5 = 1'b0;
        rst2 = 1'b0;
        rstd = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("even_e%0d", i + 1), cd4, e4[i]);
            chk($sformatf("odd_e%0d", i + 1), cd5, e5[i]);
            chk($sformatf("clamp_e%0d", i + 1), cd2, e2[i]);
        end

        // u4 now sits at cnt=2 with clk_div high.
        chk("mid_pre_hi", cd4, 1'b1);
        rst4 = 1'b1;
        #2;
        chk("sync_rst_wait", cd4, 1'b1);
        tick();
        chk("mid_rst_lo", cd4, 1'b0);
        chk_i("mid_rst_cnt", int'(u4.cnt_q), 0);
        rst4 = 1'b0;
        tick();
        chk("mid_rel_e1", cd4, 1'b0);
        tick();
        chk("mid_rel_e2", cd4, 1'b1);

        rst4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold_e%0d", i + 1), cd4, 1'b0);
        end
        rst4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("rel_e%0d", i + 1), cd4, e4[i]);
        end

        rstd = 1'b1;
        tick();
        chk("dflt_rst", cdd, 1'b0);
        rstd = 1'b0;
        bad = 0;
        for (int p = 0; p < 3; p++) begin
            hi = 0;
            for (int i = 1; i <= 5208; i++) begin
                tick();
                n  = (p * 5208 + i) % 5208;
                ex = (n >= 2604);
                if (cdd !== ex) bad++;
                if (cdd === 1'b1) hi++;
            end
            chk_i($sformatf("dflt_hi_p%0d", p), hi, 2604);
            chk("dflt_wrap_lo", cdd, 1'b0);
        end
        chk_i("dflt_shape", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
